// File: rtl/cmd_pkg.sv
// Shared types and C0 field layout for the host command deframer.
package cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_C1,
        GET_C2,
        GET_C3,
        GET_C4,
        ISSUE
    } state_t;

    localparam int PTT_BIT   = 0;
    localparam int ADDR_LSB  = 1;
    localparam int ADDR_MSB  = 6;
    localparam int RESP_BIT  = 7;
    localparam int CMD_BYTES = 5;

    localparam int ADDR_W = ADDR_MSB - ADDR_LSB + 1;
    localparam int DATA_W = 8 * (CMD_BYTES - 1);

    // State reached after a data byte is taken in one of the GET states.
    function automatic state_t after_data_byte(input state_t s);
        case (s)
            GET_C1:  return GET_C2;
            GET_C2:  return GET_C3;
            GET_C3:  return GET_C4;
            GET_C4:  return ISSUE;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Inter-byte idle counter; expire flags the last allowed idle cycle of a group.
module cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = en && !clr && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cmd_deframer.sv
// Reassembles 5-byte C0..C4 host groups into single-cycle radio control commands,
// with downstream backpressure, truncation/timeout aborts and event statistics.
module cmd_deframer
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ERR_W          = 8,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             din_sop,
    output logic             din_ready,
    input  logic             cmd_busy,
    output logic [5:0]       cmd_addr,
    output logic [31:0]      cmd_data,
    output logic             cmd_rqst,
    output logic             cmd_requires_resp,
    output logic             cmd_ptt,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] cmd_count
);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              latch_c0;
    logic              shift_byte;
    logic              err_evt;
    logic              issue_evt;
    logic              tmo_en;
    logic              tmo_clr;
    logic              tmo_expire;
    logic [7:0]        c0_sh;
    logic [DATA_W-1:0] data_sh;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign din_ready = (state != ISSUE);
    assign accept    = din_valid & din_ready;
    assign tmo_en    = (state inside {GET_C1, GET_C2, GET_C3, GET_C4});
    // Held at zero outside the GET states, so ISSUE never runs the timeout.
    assign tmo_clr   = accept | ~tmo_en;

    cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_comb begin
        state_nxt  = state;
        latch_c0   = 1'b0;
        shift_byte = 1'b0;
        err_evt    = 1'b0;
        issue_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && din_sop) begin
                    latch_c0  = 1'b1;
                    state_nxt = GET_C1;
                end
            end
            GET_C1, GET_C2, GET_C3, GET_C4: begin
                // An accepted byte masks expiry, so an abort and a timeout count once.
                if (accept) begin
                    if (din_sop) begin
                        err_evt   = 1'b1;
                        latch_c0  = 1'b1;
                        state_nxt = GET_C1;
                    end else begin
                        shift_byte = 1'b1;
                        state_nxt  = after_data_byte(state);
                    end
                end else if (tmo_expire) begin
                    err_evt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (!cmd_busy) begin
                    issue_evt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cmd_addr          <= '0;
            cmd_data          <= '0;
            cmd_rqst          <= 1'b0;
            cmd_requires_resp <= 1'b0;
            cmd_ptt           <= 1'b0;
            err_pulse         <= 1'b0;
            err_count         <= '0;
            cmd_count         <= '0;
        end else begin
            state     <= state_nxt;
            cmd_rqst  <= issue_evt;
            err_pulse <= err_evt;
            if (err_evt) begin
                err_count <= sat_inc(err_count);
            end
            if (issue_evt) begin
                cmd_addr          <= c0_sh[ADDR_MSB:ADDR_LSB];
                cmd_data          <= data_sh;
                cmd_requires_resp <= c0_sh[RESP_BIT];
                cmd_ptt           <= c0_sh[PTT_BIT];
                cmd_count         <= cmd_count + CNT_W'(1);
            end
        end
    end

    // Shadow group registers; only read after a complete group, so no reset needed.
    always_ff @(posedge clk) begin
        if (latch_c0) begin
            c0_sh <= din;
        end
        if (shift_byte) begin
            data_sh <= {data_sh[DATA_W-9:0], din};
        end
    end

endmodule

// File: tb/tb_cmd_deframer.sv
// Directed self-checking bench for cmd_deframer with hand-computed expectations.
module tb_cmd_deframer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_sop;
    logic        din_ready;
    logic        cmd_busy;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    logic        cmd_requires_resp;
    logic        cmd_ptt;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [15:0] cmd_count;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          rqst_seen = 0;
    int          err_seen = 0;
    int          rqst_cyc [0:7];
    logic [31:0] rqst_dat [0:7];

    cmd_deframer #(
        .TIMEOUT_CYCLES(256),
        .ERR_W(8),
        .CNT_W(16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .din               (din),
        .din_valid         (din_valid),
        .din_sop           (din_sop),
        .din_ready         (din_ready),
        .cmd_busy          (cmd_busy),
        .cmd_addr          (cmd_addr),
        .cmd_data          (cmd_data),
        .cmd_rqst          (cmd_rqst),
        .cmd_requires_resp (cmd_requires_resp),
        .cmd_ptt           (cmd_ptt),
        .err_pulse         (err_pulse),
        .err_count         (err_count),
        .cmd_count         (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event recorder sampled on the inactive edge; cleared while reset is held.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            rqst_seen <= 0;
            err_seen  <= 0;
        end else begin
            if (cmd_rqst) begin
                rqst_cyc[rqst_seen % 8] <= cyc;
                rqst_dat[rqst_seen % 8] <= cmd_data;
                rqst_seen               <= rqst_seen + 1;
            end
            if (err_pulse) begin
                err_seen <= err_seen + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic sop);
        int n;
        n = 0;
        din       = b;
        din_valid = 1'b1;
        din_sop   = sop;
        while (!din_ready && n < 50) begin
            tick();
            n++;
        end
        if (!din_ready) chk("ready_wait", din_ready, 1);
        tick();
        din_valid = 1'b0;
        din_sop   = 1'b0;
    endtask

    task automatic send_group(input logic [7:0] c0, input logic [31:0] d);
        send(c0, 1'b1);
        send(d[31:24], 1'b0);
        send(d[23:16], 1'b0);
        send(d[15:8], 1'b0);
        send(d[7:0], 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        cmd_busy  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready", din_ready, 1);
        chk("rst_rqst", cmd_rqst, 0);
        chk("rst_addr", cmd_addr, 0);
        chk("rst_data", cmd_data, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_cmd_count", cmd_count, 0);
        rst_n = 1'b1;
        tick();

        // Full group, no backpressure
        send_group(8'h93, 32'h0088_0000);
        chk("g1_rqst_early", cmd_rqst, 0);
        chk("g1_ready_issue", din_ready, 0);
        tick();
        chk("g1_rqst", cmd_rqst, 1);
        chk("g1_addr", cmd_addr, 6'h09);
        chk("g1_ptt", cmd_ptt, 1);
        chk("g1_resp", cmd_requires_resp, 1);
        chk("g1_data", cmd_data, 32'h0088_0000);
        chk("g1_cmd_count", cmd_count, 1);
        tick();
        chk("g1_rqst_one_cycle", cmd_rqst, 0);
        chk("g1_data_hold", cmd_data, 32'h0088_0000);

        // Backpressure for 10 cycles after C4
        cmd_busy = 1'b1;
        send_group(8'h93, 32'h0088_0000);
        for (int i = 0; i < 10; i++) begin
            chk("bp_ready_low", din_ready, 0);
            chk("bp_no_rqst", cmd_rqst, 0);
            tick();
        end
        cmd_busy = 1'b0;
        tick();
        chk("bp_rqst", cmd_rqst, 1);
        chk("bp_cmd_count", cmd_count, 2);
        chk("bp_err_count", err_count, 0);

        // Truncated group followed by a fresh one
        send(8'h20, 1'b1);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h21, 1'b1);
        chk("tr_err_pulse", err_pulse, 1);
        chk("tr_err_count", err_count, 1);
        send(8'hAA, 1'b0);
        chk("tr_err_pulse_once", err_pulse, 0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        tick();
        chk("tr_rqst", cmd_rqst, 1);
        chk("tr_addr", cmd_addr, 6'h10);
        chk("tr_data", cmd_data, 32'hAABB_CCDD);
        chk("tr_ptt", cmd_ptt, 1);
        chk("tr_resp", cmd_requires_resp, 0);
        chk("tr_cmd_count", cmd_count, 3);

        // Timeout after C2
        send(8'h12, 1'b1);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        for (int i = 0; i < 255; i++) tick();
        chk("to_not_yet", err_pulse, 0);
        tick();
        chk("to_err_pulse", err_pulse, 1);
        chk("to_err_count", err_count, 2);
        tick();
        chk("to_rqst_total", rqst_seen, 3);
        send_group(8'h7E, 32'h0102_0304);
        tick();
        chk("to_next_rqst", cmd_rqst, 1);
        chk("to_next_addr", cmd_addr, 6'h3F);
        chk("to_next_ptt", cmd_ptt, 0);
        chk("to_next_data", cmd_data, 32'h0102_0304);
        chk("to_next_cmd_count", cmd_count, 4);

        // Fresh reset, then strays and two back-to-back groups
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst2_cmd_count", cmd_count, 0);
        send(8'hFF, 1'b0);
        send(8'h55, 1'b0);
        send(8'hAA, 1'b0);
        send_group(8'h05, 32'hDEAD_BEEF);
        send_group(8'hC4, 32'h1234_5678);
        tick();
        chk("b2b_rqst", cmd_rqst, 1);
        chk("b2b_addr", cmd_addr, 6'h22);
        chk("b2b_resp", cmd_requires_resp, 1);
        chk("b2b_ptt", cmd_ptt, 0);
        chk("b2b_data", cmd_data, 32'h1234_5678);
        tick();
        chk("b2b_rqst_total", rqst_seen, 2);
        chk("b2b_gap", rqst_cyc[1] - rqst_cyc[0], 6);
        chk("b2b_first_data", rqst_dat[0], 32'hDEAD_BEEF);
        chk("b2b_cmd_count", cmd_count, 2);
        chk("b2b_err_count", err_count, 0);
        chk("b2b_err_seen", err_seen, 0);

        // Reset asserted mid-group
        send(8'h93, 1'b1);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_count", cmd_count, 0);
        chk("mid_rst_addr", cmd_addr, 0);
        chk("mid_rst_data", cmd_data, 0);
        chk("mid_rst_ptt", cmd_ptt, 0);
        chk("mid_rst_resp", cmd_requires_resp, 0);
        chk("mid_rst_ready", din_ready, 1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_rst_no_rqst", rqst_seen, 0);
        chk("mid_rst_ready_after", din_ready, 1);
        chk("mid_rst_err_count", err_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
